wb_fb_reader: RTL and testbench

- Wishbone bus master that fetches a framebuffer region word by word from a Wishbone memory responder (wb_ram or SDRAM controller) for photoframe display scan-out.
- Returned words go into an internal FIFO and are presented on a valid/ready pixel stream to the display timing block.
- One frame is fetched per start pulse.

---
 rtl/wb_fb_reader.sv | 219 +++++++++++++++++++++
 tb/tb_wb_fb_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fb_reader.sv
// Wishbone framebuffer reader: fetches LINE_WORDS*LINES words per start pulse into a FWFT FIFO feeding a pixel stream.
// Optional sticky underflow flag on underflow_o when WB_FB_UNDERFLOW_DET_EN is defined.
module wb_fb_reader #(
    parameter int LINE_WORDS = 160,
    parameter int LINES      = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [31:0] base_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    output logic [31:0] px_data_o,
    output logic        px_valid_o,
    input  logic        px_ready_i,
    output logic        busy_o,
    output logic        frame_done_o
`ifdef WB_FB_UNDERFLOW_DET_EN
    ,
    output logic        underflow_o
`endif
);

    localparam int TOTAL_WORDS = LINE_WORDS * LINES;
    localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);
    localparam int OCC_W       = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_WORDS);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] ZERO_OCC = {OCC_W{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [31:0]      adr_r;
    logic [31:0]      adr_s;
    logic             stb_r;
    logic             stb_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic [CNT_W-1:0] word_cnt_r;
    logic [CNT_W-1:0] word_cnt_s;
    logic             push_s;
    logic             pop_s;
    logic             start_acc_s;

    logic [31:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;

    logic             unused_s;
    assign unused_s = ^base_i[1:0];

    // Next-state logic for the fetch sequencer; requests are only issued when a FIFO slot is free.
    always_comb begin
        state_s     = state_r;
        adr_s       = adr_r;
        stb_s       = stb_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        word_cnt_s  = word_cnt_r;
        push_s      = 1'b0;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    start_acc_s = 1'b1;
                    adr_s       = {base_i[31:2], 2'b00};
                    word_cnt_s  = {CNT_W{1'b0}};
                    busy_s      = 1'b1;
                    state_s     = ST_HOLD;
                end else begin
                    busy_s = 1'b0;
                    stb_s  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (occ_r < FULL_OCC) begin
                    stb_s   = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    stb_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (wbm_ack_i) begin
                    push_s     = 1'b1;
                    adr_s      = adr_r + 32'd4;
                    word_cnt_s = word_cnt_r + CNT_W'(1);
                    stb_s      = 1'b0;
                    state_s    = ST_GAP;
                    // frame_done_o is registered, so raising it here makes it high during GAP
                    if (word_cnt_s == LAST_CNT) begin
                        done_s = 1'b1;
                    end else begin
                        done_s = 1'b0;
                    end
                end else begin
                    stb_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (word_cnt_r == LAST_CNT) begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                stb_s   = 1'b0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO pop request: only an accepted head word advances the read side.
    always_comb begin
        if (px_ready_i && (occ_r != ZERO_OCC)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Sequencer registers; reset drops the strobe at the same edge so a late ack lands in IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_r    <= ST_IDLE;
            adr_r      <= 32'h0000_0000;
            stb_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            adr_r      <= adr_s;
            stb_r      <= stb_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            word_cnt_r <= word_cnt_s;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_n_i && push_s) begin
            fifo_mem_r[wr_ptr_r] <= wbm_dat_i;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= ZERO_OCC;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

`ifdef WB_FB_UNDERFLOW_DET_EN
    logic underflow_r;

    // Sticky underflow: consumer wants data mid-fetch but the FIFO is empty.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            underflow_r <= 1'b0;
        end else if (start_acc_s) begin
            underflow_r <= 1'b0;
        end else if (px_ready_i && (occ_r == ZERO_OCC) && busy_r) begin
            underflow_r <= 1'b1;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign underflow_o = underflow_r;
`endif

    assign wbm_adr_o    = adr_r;
    assign wbm_dat_o    = 32'h0000_0000;
    assign wbm_we_o     = 1'b0;
    assign wbm_sel_o    = 4'hF;
    assign wbm_stb_o    = stb_r;
    assign wbm_cyc_o    = stb_r;
    assign busy_o       = busy_r;
    assign frame_done_o = done_r;
    assign px_valid_o   = (occ_r != ZERO_OCC);
    assign px_data_o    = (occ_r != ZERO_OCC) ? fifo_mem_r[rd_ptr_r] : 32'h0000_0000;

endmodule

// File: tb/tb_wb_fb_reader.sv
// Directed bench for wb_fb_reader (4 words x 2 lines, 4-entry FIFO) with a wait-state Wishbone responder model.
module tb_wb_fb_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic        wbm_stb;
    logic        wbm_cyc;
    logic        wbm_ack;
    logic [31:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        busy;
    logic        frame_done;
`ifdef WB_FB_UNDERFLOW_DET_EN
    logic        underflow;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          lat = 1;
    bit          stall = 1'b0;
    int          wait_cnt = 0;
    int          lo_chk = 0;
    int          ack_idx = 0;
    int          px_idx = 0;
    int          done_cnt = 0;
    logic [31:0] held_adr = 32'h0;
    logic [31:0] ack_base = 32'h0;
    logic [31:0] px_base = 32'h0;
    logic [31:0] seen_adr [8];

    always #5 clk = ~clk;

    wb_fb_reader #(.LINE_WORDS(4), .LINES(2), .FIFO_DEPTH(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .start_i      (start),
        .base_i       (base),
        .wbm_adr_o    (wbm_adr),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_we_o     (wbm_we),
        .wbm_sel_o    (wbm_sel),
        .wbm_stb_o    (wbm_stb),
        .wbm_cyc_o    (wbm_cyc),
        .wbm_ack_i    (wbm_ack),
        .px_data_o    (px_data),
        .px_valid_o   (px_valid),
        .px_ready_i   (px_ready),
        .busy_o       (busy),
        .frame_done_o (frame_done)
`ifdef WB_FB_UNDERFLOW_DET_EN
        ,
        .underflow_o  (underflow)
`endif
    );

    // Memory image: word 0x1000+i lives at byte address 0x100+4i.
    function automatic logic [31:0] data_at(input logic [31:0] a);
        return 32'h0000_1000 + ((a - 32'h0000_0100) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_test(input logic [31:0] b);
        ack_base = b;
        px_base  = b;
        ack_idx  = 0;
        px_idx   = 0;
        done_cnt = 0;
        base     = b;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        base     = 32'h0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            step(1);
            i++;
        end
        check("idle_in_budget", 32'(busy), 32'h0);
    endtask

    task automatic frame_counts(input string tag);
        check({tag, "_acks"}, 32'(ack_idx), 32'd8);
        check({tag, "_px"}, 32'(px_idx), 32'd8);
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_valid"}, 32'(px_valid), 32'h0);
    endtask

    // Responder: acks after `lat` cycles of strobe, checks address stability, ordering and the post-ack gap.
    always @(negedge clk) begin
        check("cyc_eq_stb", 32'(wbm_cyc), 32'(wbm_stb));
        if (lo_chk > 0) begin
            check("gap_stb", 32'(wbm_stb), 32'h0);
            lo_chk--;
        end
        if (wbm_stb) begin
            if (wait_cnt > 0) begin
                check("adr_stable", wbm_adr, held_adr);
            end else begin
                held_adr = wbm_adr;
            end
            if (!stall && wait_cnt >= lat - 1) begin
                wbm_ack   = 1'b1;
                wbm_dat_i = data_at(wbm_adr);
                check("adr_seq", wbm_adr, ack_base + 32'(4 * ack_idx));
                if (ack_idx < 8) begin
                    seen_adr[ack_idx] = wbm_adr;
                end
                ack_idx++;
                lo_chk = 2;
            end else begin
                wbm_ack = 1'b0;
            end
            wait_cnt++;
        end else begin
            wbm_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Pixel consumer scoreboard and frame_done counter.
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            check("done_after_last_ack", 32'(ack_idx), 32'd8);
        end
        if (px_valid && px_ready) begin
            check("px_data", px_data, data_at(px_base + 32'(4 * px_idx)));
            px_idx++;
        end
    end

    logic [31:0] wrap_tab [8];

    initial begin
        wrap_tab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                     32'h0000_0008, 32'h0000_000C, 32'h0000_0010, 32'h0000_0014};
        rst_n     = 1'b0;
        start     = 1'b0;
        base      = 32'h0;
        px_ready  = 1'b0;
        wbm_ack   = 1'b0;
        wbm_dat_i = 32'h0;
        step(3);
        check("rst_stb", 32'(wbm_stb), 32'h0);
        check("rst_cyc", 32'(wbm_cyc), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(frame_done), 32'h0);
        check("rst_valid", 32'(px_valid), 32'h0);
        check("rst_adr", wbm_adr, 32'h0);
        check("rst_pxdata", px_data, 32'h0);
        check("we_const", 32'(wbm_we), 32'h0);
        check("sel_const", 32'(wbm_sel), 32'hF);
        check("dat_o_const", wbm_dat_o, 32'h0);
        rst_n = 1'b1;
        step(1);

        // Basic fetch
        px_ready = 1'b1;
        lat = 1;
        begin_test(32'h100);
        check("busy_after_start", 32'(busy), 32'h1);
        wait_idle(200);
        step(6);
        frame_counts("basic");
        for (int i = 0; i < 8; i++) begin
            check("basic_adr", seen_adr[i], 32'h100 + 32'(4 * i));
        end

        // Backpressure: FIFO fills after exactly 4 acks
        px_ready = 1'b0;
        begin_test(32'h100);
        step(40);
        check("bp_acks", 32'(ack_idx), 32'd4);
        check("bp_stb", 32'(wbm_stb), 32'h0);
        check("bp_busy", 32'(busy), 32'h1);
        check("bp_head", px_data, 32'h1000);
        px_ready = 1'b1;
        wait_idle(200);
        step(6);
        frame_counts("bp");

        // Wait-stated responder
        lat = 5;
        begin_test(32'h100);
        wait_idle(300);
        step(6);
        frame_counts("wait5");

        // start_i while busy is ignored
        lat = 1;
        begin_test(32'h100);
        step(6);
        base  = 32'h300;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle(200);
        step(6);
        frame_counts("start_busy");
        check("start_busy_last_adr", seen_adr[7], 32'h11C);

        // Reset while in REQ with words queued
        px_ready = 1'b0;
        lat = 5;
        begin_test(32'h100);
        for (int i = 0; i < 200 && !(ack_idx >= 2 && wbm_stb); i++) begin
            step(1);
        end
        check("reach_req", 32'(wbm_stb), 32'h1);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_stb", 32'(wbm_stb), 32'h0);
        check("mid_rst_cyc", 32'(wbm_cyc), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_valid", 32'(px_valid), 32'h0);
        rst_n = 1'b1;
        px_ready = 1'b1;
        lat = 1;
        step(1);
        begin_test(32'h200);
        wait_idle(200);
        step(6);
        frame_counts("after_rst");
        check("after_rst_adr0", seen_adr[0], 32'h200);

        // 32-bit address wrap
        begin_test(32'hFFFF_FFF8);
        wait_idle(200);
        step(6);
        frame_counts("wrap");
        for (int i = 0; i < 8; i++) begin
            check("wrap_adr", seen_adr[i], wrap_tab[i]);
        end

`ifdef WB_FB_UNDERFLOW_DET_EN
        // Stalled responder with a hungry consumer sets the sticky flag
        stall = 1'b1;
        begin_test(32'h100);
        check("uf_clear_on_start", 32'(underflow), 32'h0);
        step(10);
        check("uf_set", 32'(underflow), 32'h1);
        stall = 1'b0;
        wait_idle(200);
        step(6);
        check("uf_sticky", 32'(underflow), 32'h1);
        begin_test(32'h100);
        check("uf_cleared", 32'(underflow), 32'h0);
        wait_idle(200);
        step(6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
